// File: rtl/bram_width_converter.sv
// BRAM-to-BRAM width converter: repacks a stream of IN_WIDTH-bit source words
// into OUT_WIDTH-bit destination words, LSB-first, with runtime base addresses.
module bram_width_converter #(
    parameter  int IN_WIDTH               = 32,
    parameter  int OUT_WIDTH              = 8,
    parameter  int SOURCE_BRAM_DEPTH      = 4,
    parameter  int DESTINATION_BRAM_DEPTH = 16,
    localparam int SA = $clog2(SOURCE_BRAM_DEPTH),
    localparam int DA = $clog2(DESTINATION_BRAM_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [DA:0]          i_num_out,
    input  logic [SA-1:0]        i_src_base,
    input  logic [DA-1:0]        i_dst_base,
    output logic                 o_busy,
    output logic                 o_done,
    input  logic [IN_WIDTH-1:0]  i_wide_in,
    output logic [SA-1:0]        o_wide_in_addr,
    output logic                 o_wide_in_rd,
    output logic [OUT_WIDTH-1:0] o_narrow_out,
    output logic [DA-1:0]        o_narrow_out_addr,
    output logic                 o_narrow_out_en
);

    localparam int BW = IN_WIDTH + OUT_WIDTH - 1;
    localparam int CW = $clog2(BW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SA-1:0]   rd_idx_q, rd_idx_d;
    logic [DA-1:0]   wr_idx_q, wr_idx_d;
    logic [DA:0]     rem_q, rem_d;
    logic [SA-1:0]   src_base_q, src_base_d;
    logic [DA-1:0]   dst_base_q, dst_base_d;

    always_comb begin
        state_d           = state_q;
        buf_d             = buf_q;
        cnt_d             = cnt_q;
        rd_idx_d          = rd_idx_q;
        wr_idx_d          = wr_idx_q;
        rem_d             = rem_q;
        src_base_d        = src_base_q;
        dst_base_d        = dst_base_q;
        o_done            = 1'b0;
        o_wide_in_rd      = 1'b0;
        o_wide_in_addr    = '0;
        o_narrow_out      = '0;
        o_narrow_out_addr = '0;
        o_narrow_out_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    src_base_d = i_src_base;
                    dst_base_d = i_dst_base;
                    rem_d      = i_num_out;
                    buf_d      = '0;
                    cnt_d      = '0;
                    rd_idx_d   = '0;
                    wr_idx_d   = '0;
                    state_d    = (i_num_out == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                o_wide_in_rd   = 1'b1;
                o_wide_in_addr = src_base_q + rd_idx_q;
                rd_idx_d       = rd_idx_q + 1'b1;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                buf_d   = buf_q | (BW'(i_wide_in) << cnt_q);
                cnt_d   = cnt_q + CW'(IN_WIDTH);
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else if (cnt_q < CW'(OUT_WIDTH)) begin
                    state_d = S_READ;
                end else begin
                    o_narrow_out_en   = 1'b1;
                    o_narrow_out      = buf_q[OUT_WIDTH-1:0];
                    o_narrow_out_addr = dst_base_q + wr_idx_q;
                    buf_d             = buf_q >> OUT_WIDTH;
                    cnt_d             = cnt_q - CW'(OUT_WIDTH);
                    wr_idx_d          = wr_idx_q + 1'b1;
                    rem_d             = rem_q - 1'b1;
                    // Decide on post-write values so the last write leads straight to DONE
                    if (rem_d == '0) begin
                        state_d = S_DONE;
                    end else if (cnt_d < CW'(OUT_WIDTH)) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy = (state_q != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            rem_q      <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            rem_q      <= rem_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
        end
    end

endmodule

// File: tb/tb_bram_width_converter.sv
// Scoreboard bench for bram_width_converter (32->8, depth 4 -> 16): a bit-stream
// reference model queues expected reads/writes, a negedge monitor checks them.
module tb_bram_width_converter;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  i_num_out = '0;
    logic [1:0]  i_src_base = '0;
    logic [3:0]  i_dst_base = '0;
    logic        o_busy, o_done;
    logic [31:0] i_wide_in = '0;
    logic [1:0]  o_wide_in_addr;
    logic        o_wide_in_rd;
    logic [7:0]  o_narrow_out;
    logic [3:0]  o_narrow_out_addr;
    logic        o_narrow_out_en;

    bram_width_converter dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_num_out         (i_num_out),
        .i_src_base        (i_src_base),
        .i_dst_base        (i_dst_base),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .i_wide_in         (i_wide_in),
        .o_wide_in_addr    (o_wide_in_addr),
        .o_wide_in_rd      (o_wide_in_rd),
        .o_narrow_out      (o_narrow_out),
        .o_narrow_out_addr (o_narrow_out_addr),
        .o_narrow_out_en   (o_narrow_out_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_seen = 0;

    logic [31:0] src_mem [4];
    logic [11:0] exp_wr[$];
    logic [1:0]  exp_rd[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source BRAM: data valid one cycle after the read strobe
    always @(posedge clk) if (o_wide_in_rd) i_wide_in <= src_mem[o_wide_in_addr];

    // Monitor
    always @(negedge clk) begin
        logic [11:0] e;
        logic [1:0]  r;
        if (o_narrow_out_en) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", int'(o_narrow_out_addr), int'(e[11:8]));
                check("wr_data", int'(o_narrow_out), int'(e[7:0]));
            end
        end else if (o_narrow_out_addr != '0) begin
            check("wr_addr_idle", int'(o_narrow_out_addr), 0);
        end
        if (o_wide_in_rd) begin
            if (exp_rd.size() == 0) begin
                check("unexpected_read", 1, 0);
            end else begin
                r = exp_rd.pop_front();
                check("rd_addr", int'(o_wide_in_addr), int'(r));
            end
        end else if (o_wide_in_addr != '0) begin
            check("rd_addr_idle", int'(o_wide_in_addr), 0);
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference model: flat LSB-first bit stream over the source words
    task automatic build_expect(input int sb, input int db, input int num);
        logic [31:0] w;
        logic [7:0]  d;
        int bit_i;
        for (int k = 0; k < num; k++) begin
            for (int b = 0; b < 8; b++) begin
                bit_i = k * 8 + b;
                w = src_mem[(sb + bit_i / 32) % 4];
                d[b] = w[bit_i % 32];
            end
            exp_wr.push_back({4'((db + k) % 16), d});
        end
        for (int j = 0; j < (num * 8 + 31) / 32; j++)
            exp_rd.push_back(2'((sb + j) % 4));
    endtask

    task automatic run_job(input int sb, input int db, input int num,
                           input int exp_lat, input bit busy_start);
        int d0;
        int s;
        build_expect(sb, db, num);
        d0 = done_cnt;
        @(negedge clk);
        i_start    = 1'b1;
        i_num_out  = 5'(num);
        i_src_base = 2'(sb);
        i_dst_base = 4'(db);
        s = cyc;
        @(negedge clk);
        i_start = 1'b0;
        if (busy_start) begin
            repeat (4) @(negedge clk);
            i_start    = 1'b1;
            i_num_out  = 5'd3;
            i_src_base = 2'd1;
            i_dst_base = 4'd7;
            @(negedge clk);
            i_start = 1'b0;
        end
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(posedge clk);
        @(negedge clk);
        check("done_seen", done_cnt - d0, 1);
        check("writes_left", exp_wr.size(), 0);
        check("reads_left", exp_rd.size(), 0);
        if (exp_lat >= 0) check("done_latency", done_cyc - s, exp_lat);
        if (busy_start) begin
            repeat (30) @(negedge clk);
            check("single_done", done_cnt - d0, 1);
            check("idle_after_done", int'(o_busy), 0);
        end
        exp_wr.delete();
        exp_rd.delete();
    endtask

    task automatic load_ramp();
        src_mem[0] = 32'h03020100;
        src_mem[1] = 32'h07060504;
        src_mem[2] = 32'h0B0A0908;
        src_mem[3] = 32'h0F0E0D0C;
    endtask

    initial begin
        int d0;
        int bad;
        load_ramp();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_rd", int'(o_wide_in_rd), 0);
        check("rst_en", int'(o_narrow_out_en), 0);
        i_rst = 1'b0;
        @(negedge clk);

        // Wide-to-narrow whole memory, with cycle-exact completion
        run_job(0, 0, 16, 25, 1'b0);
        // Wrapping source and destination addresses
        run_job(3, 14, 8, -1, 1'b0);
        // Empty transfer
        run_job(0, 0, 0, 1, 1'b0);
        // Second start while busy must be ignored
        run_job(0, 0, 16, 25, 1'b1);
        // Partial last word
        run_job(1, 5, 5, -1, 1'b0);

        // Reset mid-transfer after five writes
        build_expect(0, 0, 16);
        d0 = done_cnt;
        wr_seen = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_num_out = 5'd16;
        i_src_base = '0;
        i_dst_base = '0;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 100 && wr_seen < 5; i++) @(posedge clk);
        check("five_writes", int'(wr_seen >= 5), 1);
        @(negedge clk);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        exp_wr.delete();
        exp_rd.delete();
        @(negedge clk);
        i_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_busy || o_done || o_wide_in_rd || o_narrow_out_en ||
                o_wide_in_addr != 0 || o_narrow_out_addr != 0 || o_narrow_out != 0)
                bad++;
            if (i < 9) @(negedge clk);
        end
        check("outputs_zero_after_rst", bad, 0);
        check("no_done_after_rst", done_cnt - d0, 0);
        run_job(0, 0, 16, 25, 1'b0);

        // Randomised transfers
        for (int t = 0; t < 20; t++) begin
            int num;
            for (int j = 0; j < 4; j++) src_mem[j] = $urandom;
            num = $urandom_range(0, 16);
            run_job($urandom_range(0, 3), $urandom_range(0, 15), num,
                    (num == 0) ? 1 : -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
